// File: rtl/mul_div_seq.sv
// rtl/mul_div_seq.sv - sequential RISC-V M-extension multiply/divide unit
module mul_div_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  logic [1:0]         state;
  logic [CNT_W-1:0]   cnt;
  logic [2:0]         op_q;
  logic [2*WIDTH-1:0] sr;
  logic [WIDTH-1:0]   b_q;
  logic               neg_lo;
  logic               neg_hi;

  logic               sign_a, sign_b, a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic               div_zero, div_ovf;
  logic [WIDTH-1:0]   early_res;
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0] sr_next, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix, fix_res;

  assign in_ready  = (state == S_IDLE) && !rst && !flush;
  assign out_valid = (state == S_DONE);
  assign busy      = (state == S_CALC) || (state == S_FIX);

  // Operand conditioning at accept: magnitudes, sign bookkeeping and the early-exit cases.
  always_comb begin
    sign_a    = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
    sign_b    = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
    a_neg     = sign_a && in_a[WIDTH-1];
    b_neg     = sign_b && in_b[WIDTH-1];
    a_mag     = a_neg ? -in_a : in_a;
    b_mag     = b_neg ? -in_b : in_b;
    div_zero  = op[2] && (in_b == '0);
    div_ovf   = op[2] && !op[0] && (in_a == MOST_NEG) && (in_b == '1);
    early_res = div_zero ? (op[1] ? in_a : '1) : (op[1] ? '0 : in_a);
  end

  // sr holds {accumulator, multiplier} for multiply and {remainder, dividend/quotient} for divide.
  always_comb begin
    mul_sum   = {1'b0, sr[2*WIDTH-1:WIDTH]} + (sr[0] ? {1'b0, b_q} : '0);
    div_shift = {sr[2*WIDTH-1:WIDTH], sr[WIDTH-1]};
    div_diff  = div_shift - {1'b0, b_q};
    if (!op_q[2])
      sr_next = {mul_sum, sr[WIDTH-1:1]};
    else if (!div_diff[WIDTH])
      sr_next = {div_diff[WIDTH-1:0], sr[WIDTH-2:0], 1'b1};
    else
      sr_next = {div_shift[WIDTH-1:0], sr[WIDTH-2:0], 1'b0};
  end

  always_comb begin
    prod_fix = neg_lo ? -sr : sr;
    quo_fix  = neg_lo ? -sr[WIDTH-1:0] : sr[WIDTH-1:0];
    rem_fix  = neg_hi ? -sr[2*WIDTH-1:WIDTH] : sr[2*WIDTH-1:WIDTH];
    if (op_q[2])
      fix_res = op_q[1] ? rem_fix : quo_fix;
    else
      fix_res = (op_q[1:0] == 2'b00) ? prod_fix[WIDTH-1:0] : prod_fix[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      sr     <= '0;
      result <= '0;
      op_q   <= '0;
      b_q    <= '0;
      neg_lo <= 1'b0;
      neg_hi <= 1'b0;
    end else if (flush) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            op_q   <= op;
            b_q    <= b_mag;
            sr     <= {{WIDTH{1'b0}}, a_mag};
            neg_lo <= a_neg ^ b_neg;
            neg_hi <= a_neg;
            cnt    <= '0;
            if (div_zero || div_ovf) begin
              result <= early_res;
              state  <= S_DONE;
            end else begin
              state  <= S_CALC;
            end
          end
        end
        S_CALC: begin
          sr  <= sr_next;
          cnt <= cnt + CNT_W'(1);
          if (cnt == LAST_CNT) state <= S_FIX;
        end
        S_FIX: begin
          result <= fix_res;
          state  <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_seq.sv
// tb/tb_mul_div_seq.sv - directed and randomized bench for mul_div_seq against an arithmetic reference
module tb_mul_div_seq;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, flush, in_valid, in_ready, out_valid, out_ready, busy;
  logic [2:0]   op;
  logic [W-1:0] in_a, in_b, result;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    logic [2:0]   o;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] r;
    int           lat;
  } vec_t;

  vec_t dir[12];

  mul_div_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference result computed with plain wide/signed arithmetic.
  function automatic logic [W-1:0] ref_res(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [127:0] sa, sb, ua, ub, p;
    int ia, ib;
    logic ovf;
    sa = {{96{a[W-1]}}, a};
    sb = {{96{b[W-1]}}, b};
    ua = {96'b0, a};
    ub = {96'b0, b};
    ia = a;
    ib = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (o)
      3'd0: begin p = ua * ub; return p[31:0];  end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : W'(ia / ib);
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : ovf ? 32'd0 : W'(ia % ib);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    if (o[2] && (b == 0 || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
    return W + 2;
  endfunction

  task automatic run_op(input string tag, input logic [2:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp_r, input int exp_l,
                        input int hold);
    int cyc;
    @(negedge clk);
    check({tag, " in_ready"}, in_ready, 1);
    in_valid  = 1'b1;
    op        = o;
    in_a      = a;
    in_b      = b;
    out_ready = (hold == 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op       = 3'($urandom);
    in_a     = $urandom;
    in_b     = $urandom;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) check({tag, " busy"}, busy, (exp_l != 1));
    end while (!out_valid && cyc < 200);
    check({tag, " latency"}, cyc, exp_l);
    check({tag, " result"}, result, exp_r);
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        in_valid = 1'b1;
        in_a     = $urandom;
        @(negedge clk);
        check({tag, " hold valid"}, out_valid, 1);
        check({tag, " hold result"}, result, exp_r);
        check({tag, " hold in_ready"}, in_ready, 0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      check({tag, " release valid"}, out_valid, 0);
      check({tag, " release in_ready"}, in_ready, 1);
    end
  endtask

  initial begin
    logic [2:0]   ro;
    logic [W-1:0] ra, rb;
    int           seen;

    dir[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34};
    dir[1]  = '{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 34};
    dir[2]  = '{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 34};
    dir[3]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 34};
    dir[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 34};
    dir[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 34};
    dir[6]  = '{3'd5, 32'd100,        32'd7,         32'd14,        34};
    dir[7]  = '{3'd7, 32'd100,        32'd7,         32'd2,         34};
    dir[8]  = '{3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, 1};
    dir[9]  = '{3'd6, 32'd5,          32'd0,         32'd5,         1};
    dir[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1};
    dir[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op = 3'd0; in_a = '0; in_b = '0;
    repeat (3) @(negedge clk);
    check("reset in_ready", in_ready, 0);
    check("reset out_valid", out_valid, 0);
    check("reset busy", busy, 0);
    check("reset result", result, 0);
    rst = 1'b0;
    @(negedge clk);
    check("post-reset in_ready", in_ready, 1);

    for (int i = 0; i < 12; i++)
      run_op($sformatf("dir%0d", i), dir[i].o, dir[i].a, dir[i].b, dir[i].r, dir[i].lat, 0);

    run_op("hold", 3'd5, 32'd100, 32'd7, 32'd14, 34, 5);
    run_op("after_hold", 3'd7, 32'd100, 32'd7, 32'd2, 34, 0);

    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if (i % 5 == 0) begin
        ra = $urandom_range(0, 255);
        rb = $urandom_range(0, 15);
      end
      run_op($sformatf("rnd%0d", i), ro, ra, rb, ref_res(ro, ra, rb), ref_lat(ro, ra, rb), 0);
    end

    // Flush in the middle of a multiply.
    @(negedge clk);
    in_valid = 1'b1; op = 3'd0; in_a = $urandom; in_b = $urandom;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (10) @(negedge clk);
    check("flush busy before", busy, 1);
    flush = 1'b1;
    check("flush in_ready", in_ready, 0);
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("flush out_valid", out_valid, 0);
    check("flush busy", busy, 0);
    check("flush in_ready after", in_ready, 1);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("flush no result", seen, 0);
    run_op("after_flush", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, 0);

    // Reset in the middle of a divide.
    @(negedge clk);
    in_valid = 1'b1; op = 3'd5; in_a = 32'd1000; in_b = 32'd3;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    check("rst in_ready during", in_ready, 0);
    @(posedge clk);
    @(negedge clk);
    check("rst out_valid", out_valid, 0);
    check("rst busy", busy, 0);
    check("rst result", result, 0);
    check("rst in_ready", in_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    check("rst in_ready after", in_ready, 1);
    run_op("after_rst", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
